// File: rtl/id_ex_pipe_pkg.sv
// id_ex_pipe_pkg: shared pipeline definitions for the ID/EX buffer (NOP encoding, pointer width, payload layout).
package id_ex_pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0033;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // inst sits in the low word so a zero-extended NOP_INST is a well-formed bubble
    typedef struct packed {
        logic [31:0] ctrl;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] inst;
    } id_ex_t;

endpackage

// File: rtl/id_ex_pipe_ctrl.sv
// id_ex_pipe_ctrl: pointers, occupancy and handshake/flush control for the ID/EX FIFO.
module id_ex_pipe_ctrl
    import id_ex_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = ptr_w(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_vld,
    input  logic          i_hold,
    input  logic          i_flush,
    input  logic          i_rdy,
    output logic          o_rdy,
    output logic          o_vld,
    output logic          o_push,
    output logic [PW-1:0] o_wptr,
    output logic [PW-1:0] o_rptr,
    output logic [CW-1:0] o_count
);

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    // full refuses input even if the head leaves this cycle, keeping o_rdy off i_rdy
    assign o_rdy   = (count_q < CW'(DEPTH)) & ~i_hold;
    assign o_vld   = count_q != '0;
    assign o_push  = i_vld & o_rdy & ~i_flush;
    assign pop     = o_vld & i_rdy & ~i_flush;
    assign o_wptr  = wptr_q;
    assign o_rptr  = rptr_q;
    assign o_count = count_q;

    always_comb begin
        wptr_d  = i_flush ? '0 : wptr_q + PW'(o_push);
        rptr_d  = i_flush ? '0 : rptr_q + PW'(pop);
        count_d = i_flush ? '0 : count_q + CW'(o_push) - CW'(pop);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: elastic DEPTH-entry ID/EX buffer presenting NOP_DATA when empty.
// Optional ID_EX_PIPE_PERF_EN adds saturating stall/bubble counters.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int                 DATA_W   = 128,
    parameter int                 DEPTH    = 2,
    parameter logic [DATA_W-1:0]  NOP_DATA = DATA_W'(NOP_INST),
    localparam int                PW       = ptr_w(DEPTH),
    localparam int                CW       = PW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rdy,
    input  logic              i_hold,
    input  logic              i_flush,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_rdy,
    output logic [CW-1:0]     o_count
`ifdef ID_EX_PIPE_PERF_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_bubble_cnt
`endif
);

    logic              push;
    logic [PW-1:0]     wptr, rptr;
    logic [DATA_W-1:0] mem_q [DEPTH];

    id_ex_pipe_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (i_vld),
        .i_hold  (i_hold),
        .i_flush (i_flush),
        .i_rdy   (i_rdy),
        .o_rdy   (o_rdy),
        .o_vld   (o_vld),
        .o_push  (push),
        .o_wptr  (wptr),
        .o_rptr  (rptr),
        .o_count (o_count)
    );

    // payload storage is deliberately unreset; only control state clears
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wptr] <= i_data;
    end

    assign o_data = o_vld ? mem_q[rptr] : NOP_DATA;

`ifdef ID_EX_PIPE_PERF_EN
    logic [31:0] stall_q, stall_d, bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q + 32'(i_vld & ~o_rdy & ~i_flush & (stall_q != '1));
        bubble_d = bubble_q + 32'(~o_vld & i_rdy & (bubble_q != '1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign o_stall_cnt  = stall_q;
    assign o_bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed checks of id_ex_pipe at DEPTH 2, 4 and 8 sharing one input stream.
module tb_id_ex_pipe;

    localparam logic [127:0] NOP = 128'h33;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         vld = 1'b0, hold = 1'b0, flush = 1'b0, rdy = 1'b0;
    logic [127:0] dat = '0;

    logic         ordy2, ovld2, ordy4, ovld4, ordy8, ovld8;
    logic [127:0] odata2, odata4, odata8;
    logic [1:0]   cnt2;
    logic [2:0]   cnt4;
    logic [3:0]   cnt8;
`ifdef ID_EX_PIPE_PERF_EN
    logic [31:0]  st2, bb2, st4, bb4, st8, bb8;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.DEPTH(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_data(dat), .o_rdy(ordy2),
        .i_hold(hold), .i_flush(flush), .o_vld(ovld2), .o_data(odata2), .i_rdy(rdy),
        .o_count(cnt2)
`ifdef ID_EX_PIPE_PERF_EN
        , .o_stall_cnt(st2), .o_bubble_cnt(bb2)
`endif
    );

    id_ex_pipe #(.DEPTH(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_data(dat), .o_rdy(ordy4),
        .i_hold(hold), .i_flush(flush), .o_vld(ovld4), .o_data(odata4), .i_rdy(rdy),
        .o_count(cnt4)
`ifdef ID_EX_PIPE_PERF_EN
        , .o_stall_cnt(st4), .o_bubble_cnt(bb4)
`endif
    );

    id_ex_pipe #(.DEPTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_data(dat), .o_rdy(ordy8),
        .i_hold(hold), .i_flush(flush), .o_vld(ovld8), .o_data(odata8), .i_rdy(rdy),
        .o_count(cnt8)
`ifdef ID_EX_PIPE_PERF_EN
        , .o_stall_cnt(st8), .o_bubble_cnt(bb8)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_all();
        vld = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_vld2", 128'(ovld2), 128'h0);
        chk("rst_cnt2", 128'(cnt2), 128'h0);
        chk("rst_data2", odata2, NOP);
        chk("rst_rdy2", 128'(ordy2), 128'h1);
        hold = 1'b1;
        #1;
        chk("rst_rdy_hold2", 128'(ordy2), 128'h0);
        hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // streaming at DEPTH=2: one-cycle lag, occupancy stays at 1
        rdy = 1'b1;
        vld = 1'b1;
        dat = 128'h1;
        chk("stream_empty_data", odata2, NOP);
        chk("stream_empty_vld", 128'(ovld2), 128'h0);
        for (int i = 1; i <= 4; i++) begin
            dat = 128'(i);
            tick();
            chk("stream_data", odata2, 128'(i));
            chk("stream_cnt", 128'(cnt2), 128'h1);
        end
        vld = 1'b0;
        tick();
        chk("stream_drained", 128'(cnt2), 128'h0);
        chk("stream_drained_data", odata2, NOP);

        // fill DEPTH=2 with downstream stalled, then release
        rdy = 1'b0;
        vld = 1'b1;
        dat = 128'hA;
        tick();
        dat = 128'hB;
        tick();
        chk("full_cnt", 128'(cnt2), 128'h2);
        chk("full_rdy", 128'(ordy2), 128'h0);
        dat = 128'hC;
        tick();
        chk("refuse_cnt", 128'(cnt2), 128'h2);
        chk("refuse_head", odata2, 128'hA);
        rdy = 1'b1;
        chk("full_rdy_on_pop", 128'(ordy2), 128'h0);
        tick();
        chk("drain_b", odata2, 128'hB);
        chk("drain_b_cnt", 128'(cnt2), 128'h1);
        tick();
        chk("drain_c", odata2, 128'hC);
        chk("drain_c_cnt", 128'(cnt2), 128'h1);
        vld = 1'b0;
        tick();
        chk("drain_empty", 128'(cnt2), 128'h0);

        // flush at DEPTH=4 with a push in the same cycle
        flush_all();
        rdy = 1'b0;
        vld = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            dat = 128'(i);
            tick();
        end
        chk("pre_flush_cnt", 128'(cnt4), 128'h3);
        chk("pre_flush_head", odata4, 128'h1);
        dat = 128'hD;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vld = 1'b0;
        chk("flush_vld", 128'(ovld4), 128'h0);
        chk("flush_cnt", 128'(cnt4), 128'h0);
        chk("flush_data", odata4, NOP);
        rdy = 1'b1;
        tick();
        chk("flush_no_d", odata4, NOP);
        vld = 1'b1;
        dat = 128'hE;
        tick();
        vld = 1'b0;
        chk("post_flush_push", odata4, 128'hE);
        chk("post_flush_cnt", 128'(cnt4), 128'h1);

        // hazard hold at DEPTH=2: stored entries still drain
        flush_all();
        rdy = 1'b0;
        vld = 1'b1;
        dat = 128'h5;
        tick();
        dat = 128'h6;
        tick();
        vld = 1'b0;
        hold = 1'b1;
        rdy = 1'b1;
        chk("hold_cnt2", 128'(cnt2), 128'h2);
        chk("hold_rdy2", 128'(ordy2), 128'h0);
        chk("hold_head5", odata2, 128'h5);
        tick();
        chk("hold_cnt1", 128'(cnt2), 128'h1);
        chk("hold_rdy1", 128'(ordy2), 128'h0);
        chk("hold_head6", odata2, 128'h6);
        tick();
        chk("hold_cnt0", 128'(cnt2), 128'h0);
        chk("hold_rdy0", 128'(ordy2), 128'h0);
        hold = 1'b0;

        // continuous push/pop at DEPTH=8 across three pointer wraps
        flush_all();
        rdy = 1'b0;
        vld = 1'b1;
        dat = 128'h100;
        tick();
        rdy = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            dat = 128'(32'h100 + i);
            chk("wrap_head", odata8, 128'(32'h100 + i - 1));
            chk("wrap_cnt", 128'(cnt8), 128'h1);
            tick();
        end
        vld = 1'b0;
        chk("wrap_last", odata8, 128'h118);

        // asynchronous reset between edges with 3 entries stored
        flush_all();
        rdy = 1'b0;
        vld = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            dat = 128'(i);
            tick();
        end
        vld = 1'b0;
        chk("pre_rst_cnt", 128'(cnt4), 128'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 128'(ovld4), 128'h0);
        chk("arst_cnt", 128'(cnt4), 128'h0);
        chk("arst_data", odata4, NOP);
`ifdef ID_EX_PIPE_PERF_EN
        chk("arst_stall", 128'(st4), 128'h0);
        chk("arst_bubble", 128'(bb4), 128'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_cnt", 128'(cnt4), 128'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
